// File: rtl/dm_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_wait_ctrl
// Brief    : Data memory with req/rdy handshake, programmable wait states,
//            sub-word stores/loads and alignment/range/illegal-op faults.
// Revision : 1.0 - initial release
// ============================================================================
module dm_wait_ctrl #(
    parameter int          ADDR_W  = 12,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        rdy,
    output logic [31:0] rd,
    output logic        exc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_cnt_init = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
    localparam int         c_depth    = 2 ** ADDR_W;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_mem [0:c_depth-1];
    logic          r_we;
    logic [2:0]    r_op;
    logic [31:0]   r_addr;
    logic [31:0]   r_wd;
    logic [31:0]   r_pc;
    logic [2:0]    r_cnt;
    logic [31:0]   r_rd;
    logic          r_exc;

    logic          w_accept;
    logic          w_misalign;
    logic          w_range;
    logic          w_illegal;
    logic          w_fault;
    logic          w_finish;
    logic          w_a_we;
    logic [2:0]    w_a_op;
    logic [31:0]   w_a_addr;
    logic [31:0]   w_a_wd;
    logic [31:0]   w_a_pc;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]   w_old;
    logic [31:0]   w_merged;
    logic [31:0]   w_load;
    logic [15:0]   w_half;
    logic [7:0]    w_byte;

    assign w_accept   = (r_state == S_IDLE) && req;
    assign w_misalign = ((op == 3'd0) && (addr[1:0] != 2'b00)) ||
                        (((op == 3'd1) || (op == 3'd2)) && addr[0]);
    assign w_range    = (addr[31:ADDR_W+2] != BASE[31:ADDR_W+2]);
    assign w_illegal  = (op > 3'd4) || (we && ((op == 3'd2) || (op == 3'd4)));
    assign w_fault    = w_misalign || w_range || w_illegal;

    // Zero-latency accesses complete straight from the request inputs;
    // otherwise the latched copy is used at the final WAIT edge.
    assign w_a_we   = (r_state == S_IDLE) ? we   : r_we;
    assign w_a_op   = (r_state == S_IDLE) ? op   : r_op;
    assign w_a_addr = (r_state == S_IDLE) ? addr : r_addr;
    assign w_a_wd   = (r_state == S_IDLE) ? wd   : r_wd;
    assign w_a_pc   = (r_state == S_IDLE) ? pc   : r_pc;

    assign w_finish = ((LATENCY == 0) && w_accept && !w_fault) ||
                      ((r_state == S_WAIT) && (r_cnt == 3'd0));

    assign w_idx  = w_a_addr[ADDR_W+1:2];
    assign w_old  = r_mem[w_idx];
    assign w_half = w_old[{w_a_addr[1], 4'b0000} +: 16];
    assign w_byte = w_old[{w_a_addr[1:0], 3'b000} +: 8];

    always_comb begin
        w_merged = w_old;
        case (w_a_op)
            3'd0:    w_merged = w_a_wd;
            3'd1:    w_merged[{w_a_addr[1], 4'b0000} +: 16] = w_a_wd[15:0];
            3'd3:    w_merged[{w_a_addr[1:0], 3'b000} +: 8] = w_a_wd[7:0];
            default: w_merged = w_old;
        endcase
    end

    always_comb begin
        w_load = 32'd0;
        if (!w_a_we) begin
            case (w_a_op)
                3'd0:    w_load = w_old;
                3'd1:    w_load = {{16{w_half[15]}}, w_half};
                3'd2:    w_load = {16'd0, w_half};
                3'd3:    w_load = {{24{w_byte[7]}}, w_byte};
                3'd4:    w_load = {24'd0, w_byte};
                default: w_load = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        rdy    = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_fault || (LATENCY == 0)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= 32'd0;
            end
            r_we   <= 1'b0;
            r_op   <= 3'd0;
            r_addr <= 32'd0;
            r_wd   <= 32'd0;
            r_pc   <= 32'd0;
            r_cnt  <= 3'd0;
            r_rd   <= 32'd0;
            r_exc  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we   <= we;
                r_op   <= op;
                r_addr <= addr;
                r_wd   <= wd;
                r_pc   <= pc;
                r_cnt  <= c_cnt_init;
            end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            r_rd  <= 32'd0;
            r_exc <= w_accept && w_fault;
            if (w_finish) begin
                r_rd <= w_load;
                if (w_a_we) begin
                    r_mem[w_idx] <= w_merged;
                    $display("%d@%h: *%h <= %h", $time, w_a_pc,
                             {w_a_addr[31:2], 2'b00}, w_merged);
                end
            end
        end
    end

    assign rd  = r_rd;
    assign exc = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_dm_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_wait_ctrl
// Brief    : Directed vector bench for dm_wait_ctrl (LATENCY=2 and LATENCY=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_wait_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, req0;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr, wd, pc;
    logic        busy, rdy, exc;
    logic [31:0] rd;
    logic        busy0, rdy0, exc0;
    logic [31:0] rd0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dm_wait_ctrl #(.ADDR_W(12), .LATENCY(2), .BASE(32'h0)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .op(op), .addr(addr),
        .wd(wd), .pc(pc), .busy(busy), .rdy(rdy), .rd(rd), .exc(exc)
    );

    dm_wait_ctrl #(.ADDR_W(12), .LATENCY(0), .BASE(32'h0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .op(op), .addr(addr),
        .wd(wd), .pc(pc), .busy(busy0), .rdy(rdy0), .rd(rd0), .exc(exc0)
    );

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        exc;
        int          cyc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and return the result plus the number of cycles from
    // the accepting edge until rdy is seen (0 means it never arrived).
    task automatic access(input bit sel, input logic i_we, input logic [2:0] i_op,
                          input logic [31:0] i_addr, input logic [31:0] i_wd,
                          output logic [31:0] o_rd, output logic o_exc, output int o_cyc);
        @(negedge clk);
        we   = i_we;
        op   = i_op;
        addr = i_addr;
        wd   = i_wd;
        pc   = 32'h1000 + i_addr;
        if (sel) req0 = 1'b1; else req = 1'b1;
        @(posedge clk);
        o_cyc = 0;
        o_rd  = 32'd0;
        o_exc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req  = 1'b0;
            req0 = 1'b0;
            if (sel ? rdy0 : rdy) begin
                o_cyc = k;
                o_rd  = sel ? rd0 : rd;
                o_exc = sel ? exc0 : exc;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          c;
        int          pulses;
        logic        b4, b5, got;

        reset = 1'b1;
        req = 1'b0; req0 = 1'b0; we = 1'b0; op = 3'd0;
        addr = 32'd0; wd = 32'd0; pc = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rdy",  {31'd0, rdy},  32'd0);
        chk("reset_exc",  {31'd0, exc},  32'd0);
        chk("reset_rd",   rd,            32'd0);
        chk("reset_busy0", {31'd0, busy0}, 32'd0);

        //           we    op    addr           wd             rd             exc  cyc
        vq.push_back('{1'b1, 3'd0, 32'h0000_0004, 32'h1234_5678, 32'h0000_0000, 1'b0, 3});
        vq.push_back('{1'b0, 3'd0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0, 3});
        vq.push_back('{1'b1, 3'd3, 32'h0000_0005, 32'h0000_00AB, 32'h0000_0000, 1'b0, 3});
        vq.push_back('{1'b0, 3'd0, 32'h0000_0004, 32'h0,         32'h1234_AB78, 1'b0, 3});
        vq.push_back('{1'b0, 3'd3, 32'h0000_0005, 32'h0,         32'hFFFF_FFAB, 1'b0, 3});
        vq.push_back('{1'b0, 3'd4, 32'h0000_0005, 32'h0,         32'h0000_00AB, 1'b0, 3});
        vq.push_back('{1'b1, 3'd1, 32'h0000_0006, 32'h0000_8001, 32'h0000_0000, 1'b0, 3});
        vq.push_back('{1'b0, 3'd0, 32'h0000_0004, 32'h0,         32'h8001_AB78, 1'b0, 3});
        vq.push_back('{1'b0, 3'd1, 32'h0000_0006, 32'h0,         32'hFFFF_8001, 1'b0, 3});
        vq.push_back('{1'b0, 3'd2, 32'h0000_0006, 32'h0,         32'h0000_8001, 1'b0, 3});
        vq.push_back('{1'b0, 3'd1, 32'h0000_0004, 32'h0,         32'hFFFF_AB78, 1'b0, 3});
        vq.push_back('{1'b0, 3'd4, 32'h0000_0004, 32'h0,         32'h0000_0078, 1'b0, 3});
        vq.push_back('{1'b0, 3'd3, 32'h0000_0007, 32'h0,         32'hFFFF_FF80, 1'b0, 3});
        vq.push_back('{1'b1, 3'd3, 32'h0000_0007, 32'h0000_01FF, 32'h0000_0000, 1'b0, 3});
        vq.push_back('{1'b0, 3'd0, 32'h0000_0004, 32'h0,         32'hFF01_AB78, 1'b0, 3});
        vq.push_back('{1'b0, 3'd0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1'b1, 1});
        vq.push_back('{1'b1, 3'd1, 32'h0000_0003, 32'h0000_1234, 32'h0000_0000, 1'b1, 1});
        vq.push_back('{1'b0, 3'd6, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b1, 1});
        vq.push_back('{1'b0, 3'd0, 32'h0000_4000, 32'h0,         32'h0000_0000, 1'b1, 1});
        vq.push_back('{1'b1, 3'd2, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
        vq.push_back('{1'b1, 3'd5, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
        vq.push_back('{1'b0, 3'd0, 32'h8000_0004, 32'h0,         32'h0000_0000, 1'b1, 1});
        vq.push_back('{1'b0, 3'd0, 32'h0000_0004, 32'h0,         32'hFF01_AB78, 1'b0, 3});
        vq.push_back('{1'b0, 3'd0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, 3});
        vq.push_back('{1'b1, 3'd0, 32'h0000_3FFC, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3});
        vq.push_back('{1'b0, 3'd0, 32'h0000_3FFC, 32'h0,         32'hDEAD_BEEF, 1'b0, 3});

        foreach (vq[i]) begin
            access(1'b0, vq[i].we, vq[i].op, vq[i].addr, vq[i].wd, r, e, c);
            chk($sformatf("vec%0d_rd", i),  r,            vq[i].rd);
            chk($sformatf("vec%0d_exc", i), {31'd0, e},   {31'd0, vq[i].exc});
            chk($sformatf("vec%0d_cyc", i), c,            vq[i].cyc);
        end

        // req held high throughout a store: only the first is taken, and the
        // next accept lands on the edge after DONE returns to IDLE.
        @(negedge clk);
        we = 1'b1; op = 3'd0; addr = 32'h20; wd = 32'h0BAD_F00D; req = 1'b1;
        @(posedge clk);
        pulses = 0; b4 = 1'b1; b5 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (rdy) pulses++;
            if (k == 4) b4 = busy;
            if (k == 5) b5 = busy;
        end
        req = 1'b0;
        chk("hold_rdy_pulses", pulses, 1);
        chk("hold_idle_after_done", {31'd0, b4}, 32'd0);
        chk("hold_second_accept", {31'd0, b5}, 32'd1);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rdy) begin
                got = 1'b1;
                break;
            end
        end
        chk("hold_second_done", {31'd0, got}, 32'd1);
        access(1'b0, 1'b0, 3'd0, 32'h20, 32'h0, r, e, c);
        chk("hold_readback", r, 32'h0BAD_F00D);

        // Reset while a store is still waiting.
        @(negedge clk);
        we = 1'b1; op = 3'd0; addr = 32'h8; wd = 32'h5555_AAAA; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rdy",  {31'd0, rdy},  32'd0);
        access(1'b0, 1'b0, 3'd0, 32'h8, 32'h0, r, e, c);
        chk("abort_word8", r, 32'd0);
        chk("abort_lw_cyc", c, 3);
        access(1'b0, 1'b0, 3'd0, 32'h4, 32'h0, r, e, c);
        chk("reset_cleared_word4", r, 32'd0);

        // Zero-latency instance.
        access(1'b1, 1'b1, 3'd0, 32'h10, 32'hCAFE_F00D, r, e, c);
        chk("lat0_sw_cyc", c, 1);
        access(1'b1, 1'b0, 3'd0, 32'h10, 32'h0, r, e, c);
        chk("lat0_lw_cyc", c, 1);
        chk("lat0_lw_rd", r, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 3'd1, 32'h11, 32'h0, r, e, c);
        chk("lat0_fault_exc", {31'd0, e}, 32'd1);
        chk("lat0_fault_cyc", c, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
